// File: rtl/edm_pkg.sv
// Shared EDM definitions: pulse class codes, gap FSM state encoding and feedback word layout.
// Also used by spi_slave_cmd to decode the feedback word.
package edm_pkg;

    localparam logic [1:0] PULSE_OPEN   = 2'd0;
    localparam logic [1:0] PULSE_NORMAL = 2'd1;
    localparam logic [1:0] PULSE_SHORT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_HOLD     = 2'd2,
        ST_CLASSIFY = 2'd3
    } gap_state_t;

    localparam int FB_OPEN_LSB   = 24;
    localparam int FB_NORMAL_LSB = 16;
    localparam int FB_SHORT_LSB  = 8;
    localparam int FB_SEQ_LSB    = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/gap_pulse_classifier.sv
// Per-pulse gap classifier: edge detection on pulse_on, breakdown-delay counting and
// the IDLE/WAIT/HOLD/CLASSIFY state machine that labels each pulse OPEN/NORMAL/SHORT.
module gap_pulse_classifier
    import edm_pkg::*;
#(
    parameter logic [15:0] V_BREAK_TH    = 16'd1200,
    parameter logic [15:0] I_BREAK_TH    = 16'd300,
    parameter int          SHORT_DLY_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_operation,
    input  logic        pulse_on,
    input  logic [15:0] sample_current,
    input  logic [15:0] sample_voltage,
    output logic [1:0]  pulse_class,
    output logic        pulse_class_valid,
    output logic        class_fire,
    output logic [1:0]  class_code
);

    localparam logic [7:0] SHORT_DLY = 8'(SHORT_DLY_CYC);

    gap_state_t  state;
    gap_state_t  state_next;
    logic        pulse_q;
    logic        pulse_prev;
    logic [15:0] current_q;
    logic [15:0] voltage_q;
    logic [7:0]  dly_cnt;
    logic [7:0]  dly_next;
    logic [1:0]  cls_pend;
    logic [1:0]  cls_next;
    logic        rise;
    logic        fall;
    logic        breakdown;
    logic [1:0]  bd_class;

    // Samples are registered alongside pulse_on so a breakdown seen at the pins in the
    // same cycle as the fall is judged in the same FSM cycle. The edge history resets
    // high so a pulse already on at reset release never looks like a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q    <= 1'b1;
            pulse_prev <= 1'b1;
            current_q  <= '0;
            voltage_q  <= '0;
        end else begin
            pulse_q    <= pulse_on;
            pulse_prev <= pulse_q;
            current_q  <= sample_current;
            voltage_q  <= sample_voltage;
        end
    end

    assign rise      = pulse_q && !pulse_prev;
    assign fall      = !pulse_q && pulse_prev;
    assign breakdown = (voltage_q < V_BREAK_TH) && (current_q > I_BREAK_TH);
    assign bd_class  = (dly_cnt < SHORT_DLY) ? PULSE_SHORT : PULSE_NORMAL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dly_cnt  <= '0;
            cls_pend <= PULSE_OPEN;
        end else begin
            state    <= state_next;
            dly_cnt  <= dly_next;
            cls_pend <= cls_next;
        end
    end

    always_comb begin
        state_next = state;
        dly_next   = dly_cnt;
        cls_next   = cls_pend;
        if (!is_operation) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state_next = ST_WAIT;
                        dly_next   = '0;
                    end
                end
                ST_WAIT: begin
                    // A breakdown coinciding with the fall still counts as a breakdown.
                    if (breakdown) begin
                        cls_next   = bd_class;
                        state_next = fall ? ST_CLASSIFY : ST_HOLD;
                    end else if (fall) begin
                        cls_next   = PULSE_OPEN;
                        state_next = ST_CLASSIFY;
                    end else if (dly_cnt != 8'hFF) begin
                        dly_next = dly_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (fall) begin
                        state_next = ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign class_fire = (state == ST_CLASSIFY) && is_operation;
    assign class_code = cls_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_class       <= PULSE_OPEN;
            pulse_class_valid <= 1'b0;
        end else begin
            pulse_class_valid <= class_fire;
            if (class_fire) begin
                pulse_class <= cls_pend;
            end
        end
    end

endmodule

// File: rtl/gap_state_monitor.sv
// Gap state monitor: classifies each discharge pulse and publishes per-window class counts
// as a 32-bit feedback word with a one-cycle update strobe.
module gap_state_monitor
    import edm_pkg::*;
#(
    parameter logic [15:0] V_BREAK_TH    = 16'd1200,
    parameter logic [15:0] I_BREAK_TH    = 16'd300,
    parameter int          SHORT_DLY_CYC = 8,
    parameter int          WINDOW_PULSES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        is_operation,
    input  logic        pulse_on,
    input  logic [15:0] sample_current,
    input  logic [15:0] sample_voltage,
    output logic [1:0]  pulse_class,
    output logic        pulse_class_valid,
    output logic [31:0] feedback_data,
    output logic        feedback_valid
);

    localparam logic [7:0] WINDOW_LAST = 8'(WINDOW_PULSES - 1);

    logic       class_fire;
    logic [1:0] class_code;
    logic [7:0] open_cnt;
    logic [7:0] normal_cnt;
    logic [7:0] short_cnt;
    logic [7:0] pulse_cnt;
    logic [7:0] seq;
    logic       publish_pend;

    gap_pulse_classifier #(
        .V_BREAK_TH    (V_BREAK_TH),
        .I_BREAK_TH    (I_BREAK_TH),
        .SHORT_DLY_CYC (SHORT_DLY_CYC)
    ) u_classifier (
        .clk               (clk),
        .rst_n             (rst_n),
        .is_operation      (is_operation),
        .pulse_on          (pulse_on),
        .sample_current    (sample_current),
        .sample_voltage    (sample_voltage),
        .pulse_class       (pulse_class),
        .pulse_class_valid (pulse_class_valid),
        .class_fire        (class_fire),
        .class_code        (class_code)
    );

    // The publish happens the cycle after the window's last classification, so it can
    // never coincide with another classification (the FSM needs a new rise first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_cnt       <= '0;
            normal_cnt     <= '0;
            short_cnt      <= '0;
            pulse_cnt      <= '0;
            seq            <= '0;
            publish_pend   <= 1'b0;
            feedback_data  <= '0;
            feedback_valid <= 1'b0;
        end else begin
            feedback_valid <= 1'b0;
            if (!is_operation) begin
                open_cnt     <= '0;
                normal_cnt   <= '0;
                short_cnt    <= '0;
                pulse_cnt    <= '0;
                publish_pend <= 1'b0;
            end else if (publish_pend) begin
                feedback_data[FB_OPEN_LSB   +: 8] <= open_cnt;
                feedback_data[FB_NORMAL_LSB +: 8] <= normal_cnt;
                feedback_data[FB_SHORT_LSB  +: 8] <= short_cnt;
                feedback_data[FB_SEQ_LSB    +: 8] <= seq;
                feedback_valid <= 1'b1;
                seq            <= seq + 8'd1;
                open_cnt       <= '0;
                normal_cnt     <= '0;
                short_cnt      <= '0;
                pulse_cnt      <= '0;
                publish_pend   <= 1'b0;
            end else if (class_fire) begin
                case (class_code)
                    PULSE_OPEN:   open_cnt   <= sat_inc8(open_cnt);
                    PULSE_NORMAL: normal_cnt <= sat_inc8(normal_cnt);
                    PULSE_SHORT:  short_cnt  <= sat_inc8(short_cnt);
                    default:      open_cnt   <= open_cnt;
                endcase
                pulse_cnt    <= pulse_cnt + 8'd1;
                publish_pend <= (pulse_cnt == WINDOW_LAST);
            end
        end
    end

endmodule
